// File: rtl/run_monitor_if.sv
// run_monitor_if: groups the run monitor's bench-facing signals.
//
// Signalling: there is no valid/ready handshake on this bundle. err and done
// are plain levels, sampled on every rising clk edge while the monitor is in
// RUN and ignored otherwise. Every monitor output is a register and changes
// only on a rising edge, or asynchronously when rst_n falls.
//
// Signals
//   err         monitor <- bench  NUM_ERR error flags
//   done        monitor <- bench  DUT halt indication
//   core_rst    monitor -> DUT    active-high core reset
//   cycle_count monitor -> bench  RUN edges elapsed
//   err_src     monitor -> bench  err vector captured at the first error edge
//   err_count   monitor -> bench  saturating count of error edges
//   state       monitor -> bench  00 RESET, 01 RUN, 10 STOP, 11 DONE
//   timeout     monitor -> bench  run ended by the cycle limit
//   finished    monitor -> bench  state is STOP or DONE
//   pass        monitor -> bench  DONE with no errors
// Modports: master = the monitor, slave = the bench / processor side.
interface run_monitor_if #(
  parameter int NUM_ERR = 1,
  parameter int CNT_W   = 32
);
  logic [NUM_ERR-1:0] err;
  logic               done;
  logic               core_rst;
  logic [CNT_W-1:0]   cycle_count;
  logic [NUM_ERR-1:0] err_src;
  logic [15:0]        err_count;
  logic [1:0]         state;
  logic               timeout;
  logic               finished;
  logic               pass;

  modport master (
    input  err, done,
    output core_rst, cycle_count, err_src, err_count, state, timeout,
           finished, pass
  );

  modport slave (
    output err, done,
    input  core_rst, cycle_count, err_src, err_count, state, timeout,
           finished, pass
  );
endinterface

// File: rtl/run_monitor.sv
// run_monitor: run controller and watchdog for processor benches.
//
// Holds the core in reset for RST_CYCLES edges after rst_n releases, then
// counts RUN cycles until the DUT signals done, an error ends the run
// (ERR_STOP=1), or the cycle limit MAX_CYCLES is reached. The verdict is held
// until the next rst_n assertion.
//
// Ports
//   clk    system clock, rising edge
//   rst_n  asynchronous active-low reset
//   bus    run_monitor_if.master (err/done in; core_rst, counters, verdict out)
//
// The FSM state is driven straight onto bus.state, so it is always visible.
module run_monitor #(
  parameter int RST_CYCLES = 2,
  parameter int MAX_CYCLES = 100,
  parameter int CNT_W      = 32,
  parameter int NUM_ERR    = 1,
  parameter int ERR_STOP   = 1
) (
  input  logic          clk,
  input  logic          rst_n,
  run_monitor_if.master bus
);

  typedef enum logic [1:0] {
    ST_RESET = 2'b00,
    ST_RUN   = 2'b01,
    ST_STOP  = 2'b10,
    ST_DONE  = 2'b11
  } state_t;

  localparam int HOLD_W = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(RST_CYCLES - 1);
  localparam logic [CNT_W-1:0]  CYC_LIMIT = CNT_W'(MAX_CYCLES);

  state_t             r_state,  w_state_nxt;
  logic [HOLD_W-1:0]  r_hold,   w_hold_nxt;
  logic               r_core_rst, w_core_rst_nxt;
  logic [CNT_W-1:0]   r_cycle,  w_cycle_nxt;
  logic [NUM_ERR-1:0] r_src,    w_src_nxt;
  logic [15:0]        r_cnt,    w_cnt_nxt;
  logic               r_to,     w_to_nxt;
  logic               r_fin,    w_fin_nxt;
  logic               r_pass,   w_pass_nxt;

  logic               w_err_any;
  logic               w_err_end;

  assign w_err_any = |bus.err;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= ST_RESET;
      r_hold     <= '0;
      r_core_rst <= 1'b1;
      r_cycle    <= '0;
      r_src      <= '0;
      r_cnt      <= '0;
      r_to       <= 1'b0;
      r_fin      <= 1'b0;
      r_pass     <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_hold     <= w_hold_nxt;
      r_core_rst <= w_core_rst_nxt;
      r_cycle    <= w_cycle_nxt;
      r_src      <= w_src_nxt;
      r_cnt      <= w_cnt_nxt;
      r_to       <= w_to_nxt;
      r_fin      <= w_fin_nxt;
      r_pass     <= w_pass_nxt;
    end
  end

  always_comb begin
    w_state_nxt    = r_state;
    w_hold_nxt     = r_hold;
    w_core_rst_nxt = r_core_rst;
    w_cycle_nxt    = r_cycle;
    w_src_nxt      = r_src;
    w_cnt_nxt      = r_cnt;
    w_to_nxt       = r_to;
    w_fin_nxt      = r_fin;
    w_pass_nxt     = r_pass;
    w_err_end      = 1'b0;

    case (r_state)
      ST_RESET: begin
        // Release is registered on the last hold edge so core_rst drops
        // together with the move to RUN.
        w_core_rst_nxt = 1'b1;
        if (r_hold == HOLD_LAST) begin
          w_state_nxt    = ST_RUN;
          w_core_rst_nxt = 1'b0;
        end else begin
          w_hold_nxt = r_hold + 1'b1;
        end
      end

      ST_RUN: begin
        if (w_err_any) begin
          if (r_cnt != 16'hFFFF) begin
            w_cnt_nxt = r_cnt + 16'd1;
          end
          if (r_src == '0) begin
            w_src_nxt = bus.err;
          end
          if (ERR_STOP != 0) begin
            w_state_nxt = ST_STOP;
            w_fin_nxt   = 1'b1;
            w_err_end   = 1'b1;
          end
        end

        // Terminating edges leave cycle_count untouched.
        if (!w_err_end) begin
          if (bus.done) begin
            w_state_nxt = ST_DONE;
            w_fin_nxt   = 1'b1;
            // Uses the updated count so an error on the done edge fails the run.
            w_pass_nxt  = (w_cnt_nxt == 16'd0);
          end else if (r_cycle == CYC_LIMIT) begin
            w_state_nxt = ST_STOP;
            w_fin_nxt   = 1'b1;
            w_to_nxt    = 1'b1;
          end else begin
            w_cycle_nxt = r_cycle + 1'b1;
          end
        end
      end

      default: begin
        // STOP and DONE are absorbing until rst_n.
      end
    endcase
  end

  assign bus.core_rst    = r_core_rst;
  assign bus.cycle_count = r_cycle;
  assign bus.err_src     = r_src;
  assign bus.err_count   = r_cnt;
  assign bus.state       = r_state;
  assign bus.timeout     = r_to;
  assign bus.finished    = r_fin;
  assign bus.pass        = r_pass;

endmodule

// File: tb/tb_run_monitor.sv
// tb_run_monitor: bench for run_monitor.
//   u_a: NUM_ERR=4, ERR_STOP=1, MAX_CYCLES=100
//   u_b: NUM_ERR=4, ERR_STOP=0, MAX_CYCLES=100
//   u_c: NUM_ERR=1, ERR_STOP=0, MAX_CYCLES=70000 (err_count saturation)
module tb_run_monitor;

  localparam int MAXC  = 100;
  localparam int NEDGE = 105;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  run_monitor_if #(.NUM_ERR(4), .CNT_W(32)) if_a ();
  run_monitor_if #(.NUM_ERR(4), .CNT_W(32)) if_b ();
  run_monitor_if #(.NUM_ERR(1), .CNT_W(32)) if_c ();

  run_monitor #(.RST_CYCLES(2), .MAX_CYCLES(MAXC), .CNT_W(32), .NUM_ERR(4), .ERR_STOP(1))
    u_a (.clk(clk), .rst_n(rst_n), .bus(if_a.master));
  run_monitor #(.RST_CYCLES(2), .MAX_CYCLES(MAXC), .CNT_W(32), .NUM_ERR(4), .ERR_STOP(0))
    u_b (.clk(clk), .rst_n(rst_n), .bus(if_b.master));
  run_monitor #(.RST_CYCLES(2), .MAX_CYCLES(70000), .CNT_W(32), .NUM_ERR(1), .ERR_STOP(0))
    u_c (.clk(clk), .rst_n(rst_n), .bus(if_c.master));

  // ---------------- scoreboard ----------------
  int n_cmp = 0;
  int n_bad = 0;
  logic [31:0] exp_q[$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    if_a.err = '0; if_a.done = 1'b0;
    if_b.err = '0; if_b.done = 1'b0;
    if_c.err = '0; if_c.done = 1'b0;
  endtask

  // Leaves all instances in RUN with cycle_count 0.
  task automatic apply_reset();
    clear_inputs();
    rst_n = 1'b0;
    repeat (3) tick();
    rst_n = 1'b1;
    tick();
    tick();
  endtask

  task automatic check_out(input string tag, input int inst, input logic [1:0] xs,
                           input int xc, input logic [3:0] xsrc, input int xcnt,
                           input bit xto, input bit xpass);
    logic [1:0]  s;
    logic [31:0] c;
    logic [3:0]  src;
    logic [15:0] cnt;
    logic        to, fin, ps, cr;
    case (inst)
      0: begin s = if_a.state; c = if_a.cycle_count; src = if_a.err_src; cnt = if_a.err_count;
               to = if_a.timeout; fin = if_a.finished; ps = if_a.pass; cr = if_a.core_rst; end
      1: begin s = if_b.state; c = if_b.cycle_count; src = if_b.err_src; cnt = if_b.err_count;
               to = if_b.timeout; fin = if_b.finished; ps = if_b.pass; cr = if_b.core_rst; end
      default: begin s = if_c.state; c = if_c.cycle_count; src = {3'b000, if_c.err_src};
               cnt = if_c.err_count; to = if_c.timeout; fin = if_c.finished; ps = if_c.pass;
               cr = if_c.core_rst; end
    endcase
    chk($sformatf("%s state", tag), 64'(s), 64'(xs));
    chk($sformatf("%s cycle_count", tag), 64'(c), 64'(xc));
    chk($sformatf("%s err_src", tag), 64'(src), 64'(xsrc));
    chk($sformatf("%s err_count", tag), 64'(cnt), 64'(xcnt));
    chk($sformatf("%s timeout", tag), 64'(to), 64'(xto));
    chk($sformatf("%s finished", tag), 64'(fin), 64'(xs[1]));
    chk($sformatf("%s pass", tag), 64'(ps), 64'(xpass));
    chk($sformatf("%s core_rst", tag), 64'(cr), 64'(xs == 2'b00));
  endtask

  // ---------------- directed vector table ----------------
  typedef struct {
    bit         inst_b;
    int         e0c; logic [3:0] e0v;
    int         e1c; logic [3:0] e1v;
    int         e2c; logic [3:0] e2v;
    int         dc;
    logic [1:0] xs;
    int         xc;
    logic [3:0] xsrc;
    int         xcnt;
    bit         xto;
    bit         xpass;
  } vec_t;

  vec_t vecs[11];

  task automatic run_vec(input int idx);
    vec_t v;
    logic [3:0] e;
    v = vecs[idx];
    apply_reset();
    for (int k = 0; k < NEDGE; k++) begin
      e = (k == v.e0c) ? v.e0v : (k == v.e1c) ? v.e1v : (k == v.e2c) ? v.e2v : 4'b0000;
      if (v.inst_b) begin if_b.err = e; if_b.done = (k == v.dc); end
      else          begin if_a.err = e; if_a.done = (k == v.dc); end
      tick();
    end
    clear_inputs();
    check_out($sformatf("vec%0d", idx), v.inst_b ? 1 : 0, v.xs, v.xc, v.xsrc, v.xcnt, v.xto, v.xpass);
  endtask

  // ---------------- reference model for random runs ----------------
  logic [3:0] sched_err  [2][NEDGE];
  bit         sched_done [2][NEDGE];

  // Scans a whole schedule for the first run-ending event, then derives the
  // verdict from that index.
  task automatic predict(input int i, input bit err_stop, output logic [1:0] xs,
                         output int xc, output logic [3:0] xsrc, output int xcnt,
                         output bit xto, output bit xpass);
    int term;
    int kind; // 0 timeout, 1 error stop, 2 done
    term = MAXC;
    kind = 0;
    for (int k = 0; k <= MAXC; k++) begin
      if (err_stop && sched_err[i][k] != 0) begin term = k; kind = 1; break; end
      if (sched_done[i][k])                  begin term = k; kind = 2; break; end
    end
    xcnt = 0;
    xsrc = 4'b0000;
    for (int k = 0; k <= term; k++) begin
      if (sched_err[i][k] != 0) begin
        if (xcnt == 0) xsrc = sched_err[i][k];
        xcnt++;
      end
    end
    xc    = term;
    xs    = (kind == 2) ? 2'b11 : 2'b10;
    xto   = (kind == 0);
    xpass = (kind == 2) && (xcnt == 0);
  endtask

  // ---------------- test sequence ----------------
  initial begin
    logic [1:0] xs;
    int xc, xcnt;
    logic [3:0] xsrc;
    bit xto, xpass;

    vecs[0]  = '{0, -1, 4'h0, -1, 4'h0, -1, 4'h0,  10, 2'b11,  10, 4'h0, 0, 0, 1};
    vecs[1]  = '{0, -1, 4'h0, -1, 4'h0, -1, 4'h0,  -1, 2'b10, 100, 4'h0, 0, 1, 0};
    vecs[2]  = '{0,  5, 4'h4, -1, 4'h0, -1, 4'h0,  -1, 2'b10,   5, 4'h4, 1, 0, 0};
    vecs[3]  = '{0,  7, 4'h1, -1, 4'h0, -1, 4'h0,   7, 2'b10,   7, 4'h1, 1, 0, 0};
    vecs[4]  = '{0, -1, 4'h0, -1, 4'h0, -1, 4'h0, 100, 2'b11, 100, 4'h0, 0, 0, 1};
    vecs[5]  = '{0, -1, 4'h0, -1, 4'h0, -1, 4'h0,   0, 2'b11,   0, 4'h0, 0, 0, 1};
    vecs[6]  = '{0, 101, 4'h8, -1, 4'h0, -1, 4'h0, -1, 2'b10, 100, 4'h0, 0, 1, 0};
    vecs[7]  = '{1,  3, 4'h2,  7, 4'h8,  9, 4'h3,  12, 2'b11,  12, 4'h2, 3, 0, 0};
    vecs[8]  = '{1,  4, 4'h4, -1, 4'h0, -1, 4'h0,   4, 2'b11,   4, 4'h4, 1, 0, 0};
    vecs[9]  = '{1, 100, 4'h1, -1, 4'h0, -1, 4'h0, -1, 2'b10, 100, 4'h1, 1, 1, 0};
    vecs[10] = '{1, 100, 4'h1, -1, 4'h0, -1, 4'h0, 100, 2'b11, 100, 4'h1, 1, 0, 0};

    // Reset state and core_rst release timing.
    clear_inputs();
    rst_n = 1'b0;
    repeat (3) tick();
    check_out("reset", 0, 2'b00, 0, 4'h0, 0, 0, 0);
    rst_n = 1'b1;
    tick();
    chk("release edge1 core_rst", 64'(if_a.core_rst), 64'd1);
    chk("release edge1 state", 64'(if_a.state), 64'd0);
    tick();
    chk("release edge2 core_rst", 64'(if_a.core_rst), 64'd0);
    chk("release edge2 state", 64'(if_a.state), 64'd1);
    chk("release edge2 cycle_count", 64'(if_a.cycle_count), 64'd0);
    tick();
    chk("first run edge cycle_count", 64'(if_a.cycle_count), 64'd1);

    // Directed table.
    for (int i = 0; i < 11; i++) run_vec(i);

    // Asynchronous reset mid-run, then the release sequence again.
    apply_reset();
    repeat (40) tick();
    chk("midrun cycle_count", 64'(if_b.cycle_count), 64'd40);
    #2 rst_n = 1'b0;
    #1;
    chk("async rst state", 64'(if_b.state), 64'd0);
    chk("async rst core_rst", 64'(if_b.core_rst), 64'd1);
    chk("async rst cycle_count", 64'(if_b.cycle_count), 64'd0);
    tick();
    tick();
    rst_n = 1'b1;
    tick();
    chk("re-release edge1 core_rst", 64'(if_b.core_rst), 64'd1);
    tick();
    chk("re-release edge2 core_rst", 64'(if_b.core_rst), 64'd0);
    chk("re-release edge2 state", 64'(if_b.state), 64'd1);
    tick();
    chk("re-release first run cycle_count", 64'(if_b.cycle_count), 64'd1);

    // err_count saturation.
    apply_reset();
    if_c.err = 1'b1;
    repeat (65534) tick();
    chk("sat err_count 65534", 64'(if_c.err_count), 64'd65534);
    tick();
    chk("sat err_count 65535", 64'(if_c.err_count), 64'hFFFF);
    repeat (5) tick();
    if_c.err = 1'b0;
    chk("sat err_count held", 64'(if_c.err_count), 64'hFFFF);
    chk("sat cycle_count", 64'(if_c.cycle_count), 64'd65540);
    if_c.done = 1'b1;
    tick();
    if_c.done = 1'b0;
    check_out("sat done", 2, 2'b11, 65540, 4'h1, 65535, 0, 0);

    // Randomised runs against the model.
    for (int r = 0; r < 20; r++) begin
      for (int i = 0; i < 2; i++) begin
        for (int k = 0; k < NEDGE; k++) begin
          sched_err[i][k]  = ($urandom_range(0, 30) == 0) ? 4'($urandom_range(1, 15)) : 4'h0;
          sched_done[i][k] = ($urandom_range(0, 70) == 0);
        end
      end
      for (int i = 0; i < 2; i++) begin
        predict(i, (i == 0), xs, xc, xsrc, xcnt, xto, xpass);
        exp_q.push_back({xs, xsrc, 16'(xcnt), xto, xpass, 8'h00});
        exp_q.push_back(32'(xc));
      end
      apply_reset();
      for (int k = 0; k < NEDGE; k++) begin
        if_a.err = sched_err[0][k]; if_a.done = sched_done[0][k];
        if_b.err = sched_err[1][k]; if_b.done = sched_done[1][k];
        tick();
      end
      clear_inputs();
      for (int i = 0; i < 2; i++) begin
        logic [31:0] w0, w1;
        w0 = exp_q.pop_front();
        w1 = exp_q.pop_front();
        check_out($sformatf("rand%0d.%0d", r, i), i, w0[31:30], int'(w1), w0[29:26],
                  int'(w0[25:10]), w0[9], w0[8]);
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
